// File: rtl/shift_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// shift_serializer : FIFO-buffered byte serializer, MSB- or LSB-first per byte
// Revision 1.0
// ----------------------------------------------------------------------------
module shift_serializer #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,   // power of 2, at least 2
  parameter int DIV_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_dir,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DIV_W-1:0]              div,
  output logic                          sout,
  output logic                          sout_valid,
  output logic                          frame_start,
  output logic                          frame_end,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  // Each entry holds {dir, data}
  logic [DATA_W:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      count_d;

  state_t             state_q;
  logic [DATA_W-1:0]  shreg_q;
  logic               dir_q;
  logic [CNT_W-1:0]   bitcnt_q;
  logic [DIV_W-1:0]   baud_q;
  logic [DIV_W-1:0]   div_q;

  logic               push;
  logic               pop;
  logic               in_shift;
  logic [DATA_W:0]    head;

  assign in_ready = reset & (count_q < DEPTH_C);
  assign push     = in_valid & in_ready;
  assign pop      = (state_q == S_LOAD);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_dir, in_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      dir_q    <= 1'b0;
      bitcnt_q <= '0;
      baud_q   <= '0;
      div_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) state_q <= S_LOAD;
        end
        S_LOAD: begin
          shreg_q  <= head[DATA_W-1:0];
          dir_q    <= head[DATA_W];
          bitcnt_q <= '0;
          baud_q   <= div;
          div_q    <= div;
          state_q  <= S_SHIFT;
        end
        S_SHIFT: begin
          if (baud_q != '0) begin
            baud_q <= baud_q - DIV_W'(1);
          end else if (bitcnt_q == LAST_BIT) begin
            // Registered count decides; a same-edge push is picked up from IDLE
            state_q <= (count_q != '0) ? S_LOAD : S_IDLE;
          end else begin
            shreg_q  <= dir_q ? {1'b0, shreg_q[DATA_W-1:1]}
                              : {shreg_q[DATA_W-2:0], 1'b0};
            bitcnt_q <= bitcnt_q + CNT_W'(1);
            baud_q   <= div_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_shift    = (state_q == S_SHIFT);
  assign sout_valid  = in_shift;
  assign sout        = in_shift & (dir_q ? shreg_q[0] : shreg_q[DATA_W-1]);
  assign frame_start = in_shift && (bitcnt_q == '0) && (baud_q == div_q);
  assign frame_end   = in_shift && (bitcnt_q == LAST_BIT) && (baud_q == '0);
  assign busy        = (state_q != S_IDLE) || (count_q != '0);
  assign fifo_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_serializer.sv
`default_nettype none
// Testbench for shift_serializer: logs every cycle, rebuilds the expected frame
// timeline from the accepted bytes and compares outputs cycle by cycle.
module tb_shift_serializer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int DIVW  = 8;
  localparam int LOGN  = 2048;

  logic            clk      = 1'b0;
  logic            reset    = 1'b0;
  logic [DW-1:0]   in_data  = '0;
  logic            in_dir   = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DIVW-1:0] div      = '0;
  logic            sout;
  logic            sout_valid;
  logic            frame_start;
  logic            frame_end;
  logic            busy;
  logic [2:0]      fifo_count;

  int vectors     = 0;
  int miscompares = 0;

  shift_serializer #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .DIV_W      (DIVW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_dir      (in_dir),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .div         (div),
    .sout        (sout),
    .sout_valid  (sout_valid),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- per-cycle log (sampled at negedge) ----------------
  int  cyc    = 0;
  int  base   = 0;
  bit  log_en = 1'b0;

  logic       l_inv  [LOGN];
  logic       l_rdy  [LOGN];
  logic [7:0] l_data [LOGN];
  logic       l_dir  [LOGN];
  logic [7:0] l_div  [LOGN];
  logic [3:0] l_out  [LOGN];   // {sout_valid, sout, frame_start, frame_end}
  logic       l_busy [LOGN];
  logic [2:0] l_cnt  [LOGN];

  logic [3:0] e_out  [LOGN];
  logic       e_busy [LOGN];
  logic       e_rdy  [LOGN];
  int         e_cnt  [LOGN];

  always @(negedge clk) begin
    if (log_en && (cyc - base) < LOGN) begin
      l_inv [cyc-base] = in_valid;
      l_rdy [cyc-base] = in_ready;
      l_data[cyc-base] = in_data;
      l_dir [cyc-base] = in_dir;
      l_div [cyc-base] = div;
      l_out [cyc-base] = {sout_valid, sout, frame_start, frame_end};
      l_busy[cyc-base] = busy;
      l_cnt [cyc-base] = fifo_count;
    end
    cyc = cyc + 1;
  end

  // Reference timeline: byte i starts shifting 3 cycles after its handshake
  // cycle, or 2 cycles after the previous frame's last cycle, whichever is later.
  // Its bit period is the div present during the cycle before it starts.
  function automatic void build_expect(input int n);
    int         h[$];
    logic [7:0] dq[$];
    logic       drq[$];
    int s, e, d, k, prev_e;
    for (int c = 0; c < n; c++) begin
      e_out[c] = '0; e_busy[c] = 1'b0; e_cnt[c] = 0;
    end
    for (int c = 0; c < n; c++) begin
      if (l_inv[c] && l_rdy[c]) begin
        h.push_back(c); dq.push_back(l_data[c]); drq.push_back(l_dir[c]);
      end
    end
    foreach (h[i]) for (int c = h[i] + 1; c < n; c++) e_cnt[c]++;
    prev_e = -100;
    foreach (h[i]) begin
      s = (h[i] + 3 > prev_e + 2) ? h[i] + 3 : prev_e + 2;
      if (s - 1 >= n) break;
      d = int'(l_div[s-1]);
      e = s + DW * (d + 1) - 1;
      for (int c = s - 1; c <= e && c < n; c++) e_busy[c] = 1'b1;
      for (int c = s; c < n; c++) e_cnt[c]--;
      for (int c = s; c <= e && c < n; c++) begin
        k = (c - s) / (d + 1);
        e_out[c] = {1'b1, (drq[i] ? dq[i][k] : dq[i][DW-1-k]), (c == s), (c == e)};
      end
      prev_e = e;
    end
    for (int c = 0; c < n; c++) begin
      e_rdy[c] = (e_cnt[c] < DEPTH);
      if (e_cnt[c] != 0) e_busy[c] = 1'b1;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_log();
    @(posedge clk); #1;
    base   = cyc;
    log_en = 1'b1;
  endtask

  task automatic finish_log(input int n);
    while (cyc - base < n) @(negedge clk);
    #1 log_en = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic dir);
    bit acc;
    int t;
    in_data = d; in_dir = dir; in_valid = 1'b1;
    acc = 1'b0; t = 0;
    while (!acc && t < 300) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      t++;
    end
    if (!acc) begin
      vectors++; miscompares++;
      $display("FAIL push_accept: byte %h not accepted, in_ready=%b after %0d cycles, want accepted", d, in_ready, t);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int t;
    bit seen;
    reset = 1'b0; in_valid = 1'b0; div = '0;
    repeat (2) @(posedge clk); #1;
    vectors++;
    if ({sout_valid, sout, frame_start, frame_end, busy, in_ready, fifo_count} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_hold: outputs %b, want 000000000",
               {sout_valid, sout, frame_start, frame_end, busy, in_ready, fifo_count});
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({in_ready, busy, fifo_count} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_release: rdy=%b busy=%b cnt=%0d, want 1 0 0", in_ready, busy, fifo_count);
    end
    push_byte(8'hA5, 1'b0);
    push_byte(8'h11, 1'b1);
    in_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!frame_start && t < 50);
    vectors++;
    if (frame_start !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_frame_start: no frame_start within %0d cycles", t);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if ({sout_valid, sout} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_bit3: vld,sout=%b, want 10", {sout_valid, sout});
    end
    #1 reset = 1'b0;
    #1;
    vectors++;
    if ({sout_valid, frame_end, fifo_count, busy, in_ready} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_midframe: vld=%b fe=%b cnt=%0d busy=%b rdy=%b, want all 0",
               sout_valid, frame_end, fifo_count, busy, in_ready);
    end
    @(posedge clk); #2 reset = 1'b1;
    #1;
    vectors++;
    if ({in_ready, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_after: rdy=%b busy=%b, want 1 0", in_ready, busy);
    end
    seen = 1'b0;
    repeat (30) begin @(negedge clk); seen = seen | sout_valid | busy; end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_queue_lost: activity seen=%b after reset, want 0", seen);
    end
  endtask

  task automatic test_msb_first();
    int n = 30;
    int nv;
    logic [7:0] got;
    div = 8'd0;
    start_log();
    push_byte(8'hA5, 1'b0);
    in_valid = 1'b0;
    finish_log(n);
    build_expect(n);
    for (int c = 0; c < n; c++) begin
      vectors++;
      if ({l_out[c], l_busy[c], l_rdy[c], l_cnt[c]} !== {e_out[c], e_busy[c], e_rdy[c], 3'(e_cnt[c])}) begin
        miscompares++;
        $display("FAIL msb_first cyc %0d: got out=%b busy=%b rdy=%b cnt=%0d, want out=%b busy=%b rdy=%b cnt=%0d",
                 c, l_out[c], l_busy[c], l_rdy[c], l_cnt[c], e_out[c], e_busy[c], e_rdy[c], e_cnt[c]);
      end
    end
    got = '0; nv = 0;
    for (int c = 0; c < n; c++) if (l_out[c][3]) begin got = {got[6:0], l_out[c][2]}; nv++; end
    vectors++;
    if (got !== 8'hA5 || nv != 8) begin
      miscompares++;
      $display("FAIL msb_stream: bits %h over %0d clocks, want a5 over 8", got, nv);
    end
  endtask

  task automatic test_lsb_div();
    int n = 40;
    int nv;
    logic [23:0] got;
    div = 8'd2;
    start_log();
    push_byte(8'h0F, 1'b1);
    in_valid = 1'b0;
    finish_log(n);
    build_expect(n);
    for (int c = 0; c < n; c++) begin
      vectors++;
      if ({l_out[c], l_busy[c], l_rdy[c], l_cnt[c]} !== {e_out[c], e_busy[c], e_rdy[c], 3'(e_cnt[c])}) begin
        miscompares++;
        $display("FAIL lsb_div cyc %0d: got out=%b busy=%b rdy=%b cnt=%0d, want out=%b busy=%b rdy=%b cnt=%0d",
                 c, l_out[c], l_busy[c], l_rdy[c], l_cnt[c], e_out[c], e_busy[c], e_rdy[c], e_cnt[c]);
      end
    end
    got = '0; nv = 0;
    for (int c = 0; c < n; c++) if (l_out[c][3]) begin got = {got[22:0], l_out[c][2]}; nv++; end
    vectors++;
    if (got !== 24'hFFF000 || nv != 24) begin
      miscompares++;
      $display("FAIL lsb_stream: bits %h over %0d clocks, want fff000 over 24", got, nv);
    end
  endtask

  task automatic test_back_to_back();
    int n = 60;
    int nv, nfs;
    logic [39:0] got;
    div = 8'd0;
    start_log();
    push_byte(8'h81, 1'b0);
    push_byte(8'h81, 1'b1);
    push_byte(8'hFF, 1'b0);
    push_byte(8'h00, 1'b1);
    push_byte(8'h3C, 1'b0);
    in_valid = 1'b0;
    finish_log(n);
    build_expect(n);
    for (int c = 0; c < n; c++) begin
      vectors++;
      if ({l_out[c], l_busy[c], l_rdy[c], l_cnt[c]} !== {e_out[c], e_busy[c], e_rdy[c], 3'(e_cnt[c])}) begin
        miscompares++;
        $display("FAIL back_to_back cyc %0d: got out=%b busy=%b rdy=%b cnt=%0d, want out=%b busy=%b rdy=%b cnt=%0d",
                 c, l_out[c], l_busy[c], l_rdy[c], l_cnt[c], e_out[c], e_busy[c], e_rdy[c], e_cnt[c]);
      end
    end
    got = '0; nv = 0; nfs = 0;
    for (int c = 0; c < n; c++) begin
      if (l_out[c][3]) begin got = {got[38:0], l_out[c][2]}; nv++; end
      if (l_out[c][1]) nfs++;
    end
    vectors++;
    if (got !== 40'h8181FF003C || nv != 40 || nfs != 5) begin
      miscompares++;
      $display("FAIL b2b_stream: bits %h, %0d clocks, %0d starts; want 8181ff003c, 40, 5", got, nv, nfs);
    end
  endtask

  task automatic test_push_pop_full();
    int n = 200;
    div = 8'd3;
    start_log();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_dir   = 1'($urandom);
      step();
    end
    in_valid = 1'b0;
    finish_log(n);
    build_expect(n);
    for (int c = 0; c < n; c++) begin
      vectors++;
      if ({l_out[c], l_busy[c], l_rdy[c], l_cnt[c]} !== {e_out[c], e_busy[c], e_rdy[c], 3'(e_cnt[c])}) begin
        miscompares++;
        $display("FAIL push_pop_full cyc %0d: got out=%b busy=%b rdy=%b cnt=%0d, want out=%b busy=%b rdy=%b cnt=%0d",
                 c, l_out[c], l_busy[c], l_rdy[c], l_cnt[c], e_out[c], e_busy[c], e_rdy[c], e_cnt[c]);
      end
    end
    vectors++;
    if (l_cnt[3] !== 3'd2) begin
      miscompares++;
      $display("FAIL push_on_load: count %0d after push on LOAD clock, want 2", l_cnt[3]);
    end
    vectors++;
    if ({l_rdy[8], l_cnt[8]} !== {1'b0, 3'd4}) begin
      miscompares++;
      $display("FAIL push_when_full: rdy=%b cnt=%0d, want 0 4", l_rdy[8], l_cnt[8]);
    end
  endtask

  task automatic test_div_change();
    int n = 40;
    int t, nv;
    logic [23:0] got;
    div = 8'd1;
    start_log();
    push_byte(8'hC3, 1'b0);
    push_byte(8'h01, 1'b1);
    in_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!frame_start && t < 50);
    vectors++;
    if (frame_start !== 1'b1) begin
      miscompares++;
      $display("FAIL div_change_start: no frame_start within %0d cycles", t);
    end
    repeat (4) @(posedge clk);
    #1 div = 8'd0;
    finish_log(n);
    build_expect(n);
    for (int c = 0; c < n; c++) begin
      vectors++;
      if ({l_out[c], l_busy[c], l_rdy[c], l_cnt[c]} !== {e_out[c], e_busy[c], e_rdy[c], 3'(e_cnt[c])}) begin
        miscompares++;
        $display("FAIL div_change cyc %0d: got out=%b busy=%b rdy=%b cnt=%0d, want out=%b busy=%b rdy=%b cnt=%0d",
                 c, l_out[c], l_busy[c], l_rdy[c], l_cnt[c], e_out[c], e_busy[c], e_rdy[c], e_cnt[c]);
      end
    end
    got = '0; nv = 0;
    for (int c = 0; c < n; c++) if (l_out[c][3]) begin got = {got[22:0], l_out[c][2]}; nv++; end
    vectors++;
    if (got !== 24'hF00F80 || nv != 24) begin
      miscompares++;
      $display("FAIL div_change_stream: bits %h over %0d clocks, want f00f80 over 24", got, nv);
    end
  endtask

  task automatic test_random();
    int n = 1900;
    int gap;
    start_log();
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b0;
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        if ($urandom_range(0, 3) == 0) div = 8'($urandom_range(0, 2));
        step();
      end
      if ($urandom_range(0, 4) == 0) div = 8'($urandom_range(0, 2));
      push_byte(8'($urandom), 1'($urandom));
    end
    in_valid = 1'b0;
    finish_log(n);
    build_expect(n);
    for (int c = 0; c < n; c++) begin
      vectors++;
      if ({l_out[c], l_busy[c], l_rdy[c], l_cnt[c]} !== {e_out[c], e_busy[c], e_rdy[c], 3'(e_cnt[c])}) begin
        miscompares++;
        $display("FAIL random cyc %0d: got out=%b busy=%b rdy=%b cnt=%0d, want out=%b busy=%b rdy=%b cnt=%0d",
                 c, l_out[c], l_busy[c], l_rdy[c], l_cnt[c], e_out[c], e_busy[c], e_rdy[c], e_cnt[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_div();
    test_back_to_back();
    test_push_pop_full();
    test_div_change();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
